// File: rtl/layer_sequencer.sv
// Sequences conv -> relu -> maxpool and routes the shared feature-map BRAM to whichever stage is active.
// Define SEQ_PERF_EN to add per-stage RUN cycle counters (perf_*_cycles).
module layer_sequencer #(
  parameter int DATA_WIDTH      = 16,
  parameter int CHANNELS        = 8,
  parameter int IMG_SIZE        = 28,
  parameter int WATCHDOG_CYCLES = 1048576,
  localparam int AW = $clog2(CHANNELS * IMG_SIZE * IMG_SIZE)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic                  conv_start,
  output logic                  relu_start,
  output logic                  pool_start,
  input  logic                  conv_done,
  input  logic                  relu_done,
  input  logic                  pool_done,
  input  logic [AW-1:0]         conv_w_addr,
  input  logic                  conv_w_en,
  input  logic                  conv_w_we,
  input  logic [DATA_WIDTH-1:0] conv_w_d,
  input  logic [AW-1:0]         relu_r_addr,
  input  logic                  relu_r_en,
  input  logic [AW-1:0]         relu_w_addr,
  input  logic                  relu_w_en,
  input  logic                  relu_w_we,
  input  logic [DATA_WIDTH-1:0] relu_w_d,
  input  logic [AW-1:0]         pool_r_addr,
  input  logic                  pool_r_en,
  output logic [DATA_WIDTH-1:0] relu_r_q,
  output logic [DATA_WIDTH-1:0] pool_r_q,
  output logic [AW-1:0]         bram_r_addr,
  output logic                  bram_r_en,
  input  logic [DATA_WIDTH-1:0] bram_r_q,
  output logic [AW-1:0]         bram_w_addr,
  output logic                  bram_w_en,
  output logic                  bram_w_we,
  output logic [DATA_WIDTH-1:0] bram_w_d
`ifdef SEQ_PERF_EN
  ,
  output logic [31:0]           perf_conv_cycles,
  output logic [31:0]           perf_relu_cycles,
  output logic [31:0]           perf_pool_cycles
`endif
);

  localparam int WDW = (WATCHDOG_CYCLES > 0) ? $clog2(WATCHDOG_CYCLES + 1) : 1;
  localparam logic [WDW-1:0] WD_LAST = (WATCHDOG_CYCLES > 0) ? WDW'(WATCHDOG_CYCLES - 1) : '0;

  typedef enum logic [3:0] {
    IDLE, START_CONV, RUN_CONV, START_RELU, RUN_RELU, START_POOL, RUN_POOL, FINISH, ERROR
  } state_t;

  state_t         state_q, state_d;
  logic [WDW-1:0] wdog_q, wdog_d;
  logic           own_conv, own_relu, own_pool, in_run;
  logic           stray_req, stray_done, wdog_trip, fault;

  always_comb begin
    own_conv = (state_q == START_CONV) || (state_q == RUN_CONV);
    own_relu = (state_q == START_RELU) || (state_q == RUN_RELU);
    own_pool = (state_q == START_POOL) || (state_q == RUN_POOL);
    in_run   = (state_q == RUN_CONV) || (state_q == RUN_RELU) || (state_q == RUN_POOL);

    stray_req  = (conv_w_en && !own_conv) || ((relu_r_en || relu_w_en) && !own_relu) ||
                 (pool_r_en && !own_pool);
    stray_done = (conv_done && state_q != RUN_CONV) || (relu_done && state_q != RUN_RELU) ||
                 (pool_done && state_q != RUN_POOL);
    // A done arriving on the last allowed cycle still counts as in time.
    wdog_trip  = (WATCHDOG_CYCLES != 0) && in_run && (wdog_q == WD_LAST) &&
                 !(conv_done || relu_done || pool_done);
    fault      = stray_req || stray_done || wdog_trip;

    state_d = state_q;
    case (state_q)
      IDLE:       if (start) state_d = START_CONV;
      START_CONV: state_d = RUN_CONV;
      RUN_CONV:   if (conv_done) state_d = START_RELU;
      START_RELU: state_d = RUN_RELU;
      RUN_RELU:   if (relu_done) state_d = START_POOL;
      START_POOL: state_d = RUN_POOL;
      RUN_POOL:   if (pool_done) state_d = FINISH;
      FINISH:     state_d = IDLE;
      ERROR:      if (start) state_d = START_CONV;
      default:    state_d = IDLE;
    endcase
    if (fault) state_d = ERROR;

    wdog_d = '0;
    if ((WATCHDOG_CYCLES != 0) && in_run && (state_d == state_q)) wdog_d = wdog_q + WDW'(1);
  end

  always_comb begin
    busy        = own_conv || own_relu || own_pool;
    done        = (state_q == FINISH);
    error       = (state_q == ERROR);
    conv_start  = (state_q == START_CONV);
    relu_start  = (state_q == START_RELU);
    pool_start  = (state_q == START_POOL);
    bram_r_addr = '0;
    bram_r_en   = 1'b0;
    bram_w_addr = '0;
    bram_w_en   = 1'b0;
    bram_w_we   = 1'b0;
    bram_w_d    = '0;
    // Ownership depends only on state, so a read issued in RUN keeps its path until the stage ends.
    if (own_conv) begin
      bram_w_addr = conv_w_addr;
      bram_w_en   = conv_w_en;
      bram_w_we   = conv_w_we;
      bram_w_d    = conv_w_d;
    end
    if (own_relu) begin
      bram_r_addr = relu_r_addr;
      bram_r_en   = relu_r_en;
      bram_w_addr = relu_w_addr;
      bram_w_en   = relu_w_en;
      bram_w_we   = relu_w_we;
      bram_w_d    = relu_w_d;
    end
    if (own_pool) begin
      bram_r_addr = pool_r_addr;
      bram_r_en   = pool_r_en;
    end
  end

  assign relu_r_q = bram_r_q;
  assign pool_r_q = bram_r_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      wdog_q  <= wdog_d;
    end
  end

`ifdef SEQ_PERF_EN
  logic        accept_start;
  logic [31:0] perf_conv_q, perf_conv_d, perf_relu_q, perf_relu_d, perf_pool_q, perf_pool_d;

  assign accept_start = ((state_q == IDLE) || (state_q == ERROR)) && (state_d == START_CONV);

  always_comb begin
    perf_conv_d = perf_conv_q;
    perf_relu_d = perf_relu_q;
    perf_pool_d = perf_pool_q;
    if (accept_start) begin
      perf_conv_d = '0;
      perf_relu_d = '0;
      perf_pool_d = '0;
    end else begin
      if (state_q == RUN_CONV && perf_conv_q != '1) perf_conv_d = perf_conv_q + 32'd1;
      if (state_q == RUN_RELU && perf_relu_q != '1) perf_relu_d = perf_relu_q + 32'd1;
      if (state_q == RUN_POOL && perf_pool_q != '1) perf_pool_d = perf_pool_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_conv_q <= '0;
      perf_relu_q <= '0;
      perf_pool_q <= '0;
    end else begin
      perf_conv_q <= perf_conv_d;
      perf_relu_q <= perf_relu_d;
      perf_pool_q <= perf_pool_d;
    end
  end

  assign perf_conv_cycles = perf_conv_q;
  assign perf_relu_cycles = perf_relu_q;
  assign perf_pool_cycles = perf_pool_q;
`endif

endmodule

// File: tb/tb_layer_sequencer.sv
// Bench for layer_sequencer: randomized sequences against a cycle-interval model, plus directed fault cases.
// Runs a WATCHDOG_CYCLES=16 instance and a watchdog-disabled instance side by side on the same inputs.
module tb_layer_sequencer;

  logic        clk = 1'b0;
  logic        reset, start, conv_done, relu_done, pool_done;
  logic        busy, done, error, conv_start, relu_start, pool_start;
  logic [12:0] conv_w_addr, relu_r_addr, relu_w_addr, pool_r_addr, bram_r_addr, bram_w_addr;
  logic        conv_w_en, conv_w_we, relu_r_en, relu_w_en, relu_w_we, pool_r_en;
  logic        bram_r_en, bram_w_en, bram_w_we;
  logic [15:0] conv_w_d, relu_w_d, relu_r_q, pool_r_q, bram_r_q, bram_w_d;

  logic        busy0, done0, error0, conv_start0, relu_start0, pool_start0;
  logic [12:0] bram_r_addr0, bram_w_addr0;
  logic        bram_r_en0, bram_w_en0, bram_w_we0;
  logic [15:0] relu_r_q0, pool_r_q0, bram_w_d0;
`ifdef SEQ_PERF_EN
  logic [31:0] perf_conv_cycles, perf_relu_cycles, perf_pool_cycles;
  logic [31:0] perf_conv_cycles0, perf_relu_cycles0, perf_pool_cycles0;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  layer_sequencer #(.WATCHDOG_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .error(error),
    .conv_start(conv_start), .relu_start(relu_start), .pool_start(pool_start),
    .conv_done(conv_done), .relu_done(relu_done), .pool_done(pool_done),
    .conv_w_addr(conv_w_addr), .conv_w_en(conv_w_en), .conv_w_we(conv_w_we), .conv_w_d(conv_w_d),
    .relu_r_addr(relu_r_addr), .relu_r_en(relu_r_en),
    .relu_w_addr(relu_w_addr), .relu_w_en(relu_w_en), .relu_w_we(relu_w_we), .relu_w_d(relu_w_d),
    .pool_r_addr(pool_r_addr), .pool_r_en(pool_r_en),
    .relu_r_q(relu_r_q), .pool_r_q(pool_r_q),
    .bram_r_addr(bram_r_addr), .bram_r_en(bram_r_en), .bram_r_q(bram_r_q),
    .bram_w_addr(bram_w_addr), .bram_w_en(bram_w_en), .bram_w_we(bram_w_we), .bram_w_d(bram_w_d)
`ifdef SEQ_PERF_EN
    , .perf_conv_cycles(perf_conv_cycles), .perf_relu_cycles(perf_relu_cycles),
    .perf_pool_cycles(perf_pool_cycles)
`endif
  );

  layer_sequencer #(.WATCHDOG_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .start(start), .busy(busy0), .done(done0), .error(error0),
    .conv_start(conv_start0), .relu_start(relu_start0), .pool_start(pool_start0),
    .conv_done(conv_done), .relu_done(relu_done), .pool_done(pool_done),
    .conv_w_addr(conv_w_addr), .conv_w_en(conv_w_en), .conv_w_we(conv_w_we), .conv_w_d(conv_w_d),
    .relu_r_addr(relu_r_addr), .relu_r_en(relu_r_en),
    .relu_w_addr(relu_w_addr), .relu_w_en(relu_w_en), .relu_w_we(relu_w_we), .relu_w_d(relu_w_d),
    .pool_r_addr(pool_r_addr), .pool_r_en(pool_r_en),
    .relu_r_q(relu_r_q0), .pool_r_q(pool_r_q0),
    .bram_r_addr(bram_r_addr0), .bram_r_en(bram_r_en0), .bram_r_q(bram_r_q),
    .bram_w_addr(bram_w_addr0), .bram_w_en(bram_w_en0), .bram_w_we(bram_w_we0), .bram_w_d(bram_w_d0)
`ifdef SEQ_PERF_EN
    , .perf_conv_cycles(perf_conv_cycles0), .perf_relu_cycles(perf_relu_cycles0),
    .perf_pool_cycles(perf_pool_cycles0)
`endif
  );

  task automatic clear_inputs();
    start = 0; conv_done = 0; relu_done = 0; pool_done = 0;
    conv_w_addr = '0; conv_w_en = 0; conv_w_we = 0; conv_w_d = '0;
    relu_r_addr = '0; relu_r_en = 0;
    relu_w_addr = '0; relu_w_en = 0; relu_w_we = 0; relu_w_d = '0;
    pool_r_addr = '0; pool_r_en = 0; bram_r_q = '0;
  endtask

  task automatic pulse_reset();
    clear_inputs();
    @(negedge clk); reset = 1;
    @(negedge clk); reset = 0;
  endtask

  task automatic test_reset();
    logic [15:0] qv;
    clear_inputs();
    reset = 1;
    qv = 16'($urandom);
    bram_r_q = qv;
    repeat (2) @(negedge clk);
    #1;
    tests++;
    if ({busy, done, error, conv_start, relu_start, pool_start} !== 6'b0) begin
      fails++; $display("[TB] FAIL reset ctrl: got %b expected 000000", {busy, done, error, conv_start, relu_start, pool_start});
    end
    tests++;
    if ({bram_r_addr, bram_r_en, bram_w_addr, bram_w_en, bram_w_we, bram_w_d} !== 45'b0) begin
      fails++; $display("[TB] FAIL reset bram: got %h expected 0", {bram_r_addr, bram_r_en, bram_w_addr, bram_w_en, bram_w_we, bram_w_d});
    end
    tests++;
    if ({relu_r_q, pool_r_q} !== {qv, qv}) begin
      fails++; $display("[TB] FAIL reset rq fanout: got %h expected %h", {relu_r_q, pool_r_q}, {qv, qv});
    end
    tests++;
    if ({busy0, done0, error0, conv_start0, relu_start0, pool_start0, bram_r_addr0, bram_r_en0,
         bram_w_addr0, bram_w_en0, bram_w_we0, bram_w_d0, relu_r_q0, pool_r_q0} !== {51'b0, qv, qv}) begin
      fails++; $display("[TB] FAIL reset dut0 outputs: got %h expected %h",
        {busy0, done0, error0, conv_start0, relu_start0, pool_start0, bram_r_addr0, bram_r_en0,
         bram_w_addr0, bram_w_en0, bram_w_we0, bram_w_d0, relu_r_q0, pool_r_q0}, {51'b0, qv, qv});
    end
`ifdef SEQ_PERF_EN
    tests++;
    if ({perf_conv_cycles, perf_relu_cycles, perf_pool_cycles, perf_conv_cycles0, perf_relu_cycles0,
         perf_pool_cycles0} !== 192'b0) begin
      fails++; $display("[TB] FAIL reset perf: got %h/%h/%h expected 0", perf_conv_cycles, perf_relu_cycles, perf_pool_cycles);
    end
`endif
    reset = 0;
    bram_r_q = '0;
  endtask

  // Cycle k=0 drives start in IDLE; stage launches and the done pulse fall at fixed offsets from the latencies.
  task automatic test_sequences();
    int lc, lr, lp, b2, b3, f, own;
    logic [5:0]  exp_ctrl;
    logic [13:0] exp_r;
    logic [30:0] exp_w;
    for (int s = 0; s < 16; s++) begin
      if (s == 0) begin lc = 5; lr = 10; lp = 4; end
      else begin lc = $urandom_range(1, 12); lr = $urandom_range(1, 12); lp = $urandom_range(1, 12); end
      b2 = 2 + lc; b3 = 3 + lc + lr; f = 4 + lc + lr + lp;
      for (int k = 0; k <= f + 1; k++) begin
        @(negedge clk);
        own = (k >= 1 && k < b2) ? 1 : (k >= b2 && k < b3) ? 2 : (k >= b3 && k < f) ? 3 : 0;
        start = (k == 0);
        conv_done = (k == b2 - 1); relu_done = (k == b3 - 1); pool_done = (k == f - 1);
        conv_w_addr = 13'($urandom); conv_w_we = 1'($urandom); conv_w_d = 16'($urandom);
        relu_r_addr = 13'($urandom); relu_w_addr = 13'($urandom);
        relu_w_we = 1'($urandom); relu_w_d = 16'($urandom);
        pool_r_addr = 13'($urandom); bram_r_q = 16'($urandom);
        conv_w_en = (own == 1) ? 1'($urandom) : 1'b0;
        relu_r_en = (own == 2) ? 1'($urandom) : 1'b0;
        relu_w_en = (own == 2) ? 1'($urandom) : 1'b0;
        pool_r_en = (own == 3) ? 1'($urandom) : 1'b0;
        #1;
        exp_ctrl = {k >= 1 && k < f, k == f, 1'b0, k == 1, k == b2, k == b3};
        exp_r = '0; exp_w = '0;
        if (own == 1) exp_w = {conv_w_addr, conv_w_en, conv_w_we, conv_w_d};
        if (own == 2) begin
          exp_r = {relu_r_addr, relu_r_en};
          exp_w = {relu_w_addr, relu_w_en, relu_w_we, relu_w_d};
        end
        if (own == 3) exp_r = {pool_r_addr, pool_r_en};
        tests++;
        if ({busy, done, error, conv_start, relu_start, pool_start} !== exp_ctrl) begin
          fails++; $display("[TB] FAIL seq%0d cyc%0d ctrl: got %b expected %b", s, k, {busy, done, error, conv_start, relu_start, pool_start}, exp_ctrl);
        end
        tests++;
        if ({bram_r_addr, bram_r_en} !== exp_r) begin
          fails++; $display("[TB] FAIL seq%0d cyc%0d portA: got %h expected %h", s, k, {bram_r_addr, bram_r_en}, exp_r);
        end
        tests++;
        if ({bram_w_addr, bram_w_en, bram_w_we, bram_w_d} !== exp_w) begin
          fails++; $display("[TB] FAIL seq%0d cyc%0d portB: got %h expected %h", s, k, {bram_w_addr, bram_w_en, bram_w_we, bram_w_d}, exp_w);
        end
        tests++;
        if ({relu_r_q, pool_r_q} !== {bram_r_q, bram_r_q}) begin
          fails++; $display("[TB] FAIL seq%0d cyc%0d rq fanout: got %h expected %h", s, k, {relu_r_q, pool_r_q}, {bram_r_q, bram_r_q});
        end
`ifdef SEQ_PERF_EN
        if (k == 1) begin
          tests++;
          if ({perf_conv_cycles, perf_relu_cycles, perf_pool_cycles} !== 96'b0) begin
            fails++; $display("[TB] FAIL seq%0d perf clear: got %0d/%0d/%0d expected 0/0/0", s, perf_conv_cycles, perf_relu_cycles, perf_pool_cycles);
          end
        end
        if (k == f + 1) begin
          tests++;
          if ({perf_conv_cycles, perf_relu_cycles, perf_pool_cycles} !== {32'(lc), 32'(lr), 32'(lp)}) begin
            fails++; $display("[TB] FAIL seq%0d perf counts: got %0d/%0d/%0d expected %0d/%0d/%0d", s, perf_conv_cycles, perf_relu_cycles, perf_pool_cycles, lc, lr, lp);
          end
        end
`endif
      end
    end
    clear_inputs();
  endtask

  task automatic test_mux_violation();
    clear_inputs();
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    @(negedge clk); conv_done = 1;
    @(negedge clk); conv_done = 0;
    @(negedge clk);
    relu_r_en = 1; relu_r_addr = 13'h123; conv_w_en = 1; conv_w_addr = 13'($urandom);
    #1;
    tests++;
    if ({bram_r_addr, bram_r_en, bram_w_en} !== {13'h123, 1'b1, 1'b0}) begin
      fails++; $display("[TB] FAIL mux relu read: got addr %h en %b wen %b expected addr 123 en 1 wen 0", bram_r_addr, bram_r_en, bram_w_en);
    end
    @(negedge clk); clear_inputs(); #1;
    tests++;
    if ({busy, done, error, conv_start, relu_start, pool_start, bram_w_en, bram_r_en} !== 8'b00100000) begin
      fails++; $display("[TB] FAIL mux stray request: got %b expected 00100000", {busy, done, error, conv_start, relu_start, pool_start, bram_w_en, bram_r_en});
    end
    start = 1;
    @(negedge clk); start = 0; #1;
    tests++;
    if ({busy, done, error, conv_start, relu_start, pool_start} !== 6'b100100) begin
      fails++; $display("[TB] FAIL mux restart: got %b expected 100100", {busy, done, error, conv_start, relu_start, pool_start});
    end
    pulse_reset();
  endtask

  task automatic test_spurious_done();
    clear_inputs();
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    @(negedge clk); pool_done = 1;
    @(negedge clk); pool_done = 0; #1;
    tests++;
    if ({busy, done, error, conv_start, relu_start, pool_start} !== 6'b001000) begin
      fails++; $display("[TB] FAIL spurious pool_done: got %b expected 001000", {busy, done, error, conv_start, relu_start, pool_start});
    end
    start = 1;
    @(negedge clk); start = 0; #1;
    tests++;
    if ({busy, done, error, conv_start, relu_start, pool_start} !== 6'b100100) begin
      fails++; $display("[TB] FAIL spurious restart: got %b expected 100100", {busy, done, error, conv_start, relu_start, pool_start});
    end
    pulse_reset();
  endtask

  task automatic test_done_in_start();
    clear_inputs();
    @(negedge clk); start = 1;
    @(negedge clk); start = 0; conv_done = 1; #1;
    tests++;
    if ({busy, done, error, conv_start, relu_start, pool_start} !== 6'b100100) begin
      fails++; $display("[TB] FAIL early done launch: got %b expected 100100", {busy, done, error, conv_start, relu_start, pool_start});
    end
    @(negedge clk); conv_done = 0; #1;
    tests++;
    if ({busy, done, error, conv_start, relu_start, pool_start} !== 6'b001000) begin
      fails++; $display("[TB] FAIL done in START_CONV: got %b expected 001000", {busy, done, error, conv_start, relu_start, pool_start});
    end
    pulse_reset();
  endtask

  task automatic test_watchdog();
    clear_inputs();
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    @(negedge clk); conv_done = 1;
    @(negedge clk); conv_done = 0; #1;
    tests++;
    if ({busy, done, error, conv_start, relu_start, pool_start} !== 6'b100010) begin
      fails++; $display("[TB] FAIL watchdog relu launch: got %b expected 100010", {busy, done, error, conv_start, relu_start, pool_start});
    end
    for (int c = 0; c < 16; c++) begin
      @(negedge clk); #1;
      tests++;
      if ({busy, done, error, conv_start, relu_start, pool_start} !== 6'b100000) begin
        fails++; $display("[TB] FAIL watchdog run cycle %0d: got %b expected 100000", c, {busy, done, error, conv_start, relu_start, pool_start});
      end
    end
    @(negedge clk); #1;
    tests++;
    if ({busy, done, error, conv_start, relu_start, pool_start} !== 6'b001000) begin
      fails++; $display("[TB] FAIL watchdog trip: got %b expected 001000", {busy, done, error, conv_start, relu_start, pool_start});
    end
    repeat (10000) @(negedge clk);
    #1;
    tests++;
    if ({busy0, done0, error0, conv_start0, relu_start0, pool_start0} !== 6'b100000) begin
      fails++; $display("[TB] FAIL watchdog disabled: got %b expected 100000", {busy0, done0, error0, conv_start0, relu_start0, pool_start0});
    end
    pulse_reset();
  endtask

  task automatic test_reset_mid();
    clear_inputs();
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    @(negedge clk); conv_done = 1;
    @(negedge clk); conv_done = 0;
    @(negedge clk);
    relu_w_en = 1; relu_w_we = 1; relu_w_addr = 13'($urandom); reset = 1; #1;
    tests++;
    if (bram_w_en !== 1'b1) begin
      fails++; $display("[TB] FAIL reset_mid relu write: got %b expected 1", bram_w_en);
    end
    @(negedge clk); clear_inputs(); reset = 0; #1;
    tests++;
    if ({busy, done, error, conv_start, relu_start, pool_start, bram_r_addr, bram_r_en,
         bram_w_addr, bram_w_en, bram_w_we, bram_w_d} !== 51'b0) begin
      fails++; $display("[TB] FAIL reset_mid outputs: got %h expected 0", {busy, done, error, conv_start, relu_start, pool_start, bram_r_addr, bram_r_en, bram_w_addr, bram_w_en, bram_w_we, bram_w_d});
    end
    start = 1;
    @(negedge clk); start = 0; #1;
    tests++;
    if ({busy, done, error, conv_start, relu_start, pool_start} !== 6'b100100) begin
      fails++; $display("[TB] FAIL reset_mid relaunch: got %b expected 100100", {busy, done, error, conv_start, relu_start, pool_start});
    end
    pulse_reset();
  endtask

  initial begin
    reset = 1;
    clear_inputs();
    test_reset();
    test_sequences();
    test_mux_violation();
    test_spurious_done();
    test_done_in_start();
    test_watchdog();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
